// File: rtl/raw_data_varint_encoder.sv
// Accepts raw-data words and streams each one as a protobuf base-128 varint (LSB group first) into a byte FIFO.
// Optional: define RAW_DATA_VARINT_ZIGZAG_EN to zigzag-map captured words (protobuf sint encoding).
module raw_data_varint_encoder #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  raw_data_valid,
    input  logic [DATA_WIDTH-1:0] raw_data_in,
    output logic                  raw_data_accepted,
    input  logic                  byte_fifo_full,
    output logic [7:0]            byte_out,
    output logic                  byte_out_push,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_encoded
);

    localparam int unsigned SR_W = 64;

    typedef enum logic [0:0] {
        IDLE,
        ENCODE
    } state_t;

    state_t                 state, state_next;
    logic [SR_W-1:0]        sr, sr_next, sr_shift;
    logic                   more;
    logic                   accepted_next;
    logic [CNT_WIDTH-1:0]   count_next;
    logic [DATA_WIDTH-1:0]  word;
    logic [SR_W-1:0]        captured;

`ifdef RAW_DATA_VARINT_ZIGZAG_EN
    // Zigzag: small-magnitude signed values map to small unsigned codes.
    assign word = {raw_data_in[DATA_WIDTH-2:0], 1'b0} ^ {DATA_WIDTH{raw_data_in[DATA_WIDTH-1]}};
`else
    assign word = raw_data_in;
`endif

    assign captured = SR_W'(word);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            sr                <= '0;
            raw_data_accepted <= 1'b0;
            busy              <= 1'b0;
            words_encoded     <= '0;
        end else begin
            state             <= state_next;
            sr                <= sr_next;
            raw_data_accepted <= accepted_next;
            busy              <= (state_next == ENCODE);
            words_encoded     <= count_next;
        end
    end

    // Next-state, capture and byte emission; the FIFO-facing outputs are combinational off sr
    always_comb begin
        state_next    = state;
        sr_next       = sr;
        accepted_next = 1'b0;
        count_next    = words_encoded;
        byte_out      = 8'h00;
        byte_out_push = 1'b0;
        sr_shift      = sr >> 7;
        more          = (sr_shift != '0);

        case (state)
            IDLE: begin
                if (raw_data_valid) begin
                    sr_next       = captured;
                    accepted_next = 1'b1;
                    state_next    = ENCODE;
                end
            end
            ENCODE: begin
                byte_out      = {more, sr[6:0]};
                byte_out_push = !byte_fifo_full;
                if (!byte_fifo_full) begin
                    sr_next = sr_shift;
                    // Last group leaves sr at zero, so byte_out reads 0x00 back in IDLE
                    if (!more) begin
                        state_next = IDLE;
                        count_next = words_encoded + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_raw_data_varint_encoder.sv
// Scoreboard bench for raw_data_varint_encoder: reference varint model feeds a queue, a negedge monitor checks pushes.
module tb_raw_data_varint_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        raw_data_valid;
    logic [63:0] raw_data_in;
    logic        raw_data_accepted;
    logic        byte_fifo_full;
    logic [7:0]  byte_out;
    logic        byte_out_push;
    logic        busy;
    logic [15:0] words_encoded;

    raw_data_varint_encoder #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .raw_data_valid    (raw_data_valid),
        .raw_data_in       (raw_data_in),
        .raw_data_accepted (raw_data_accepted),
        .byte_fifo_full    (byte_fifo_full),
        .byte_out          (byte_out),
        .byte_out_push     (byte_out_push),
        .busy              (busy),
        .words_encoded     (words_encoded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_push   = 0;
    int          n_acc    = 0;
    int          n_sent   = 0;
    bit          rand_full = 1'b0;
    bit          prev_acc  = 1'b0;
    logic [15:0] exp_words = '0;
    logic [7:0]  exp_q[$];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Reference: repeated divide by 128, emitting remainders with a continuation flag
    task automatic model(input logic [63:0] x);
        logic [63:0] v;
        logic [6:0]  pay;
        v = x;
`ifdef RAW_DATA_VARINT_ZIGZAG_EN
        v = (x << 1) ^ {64{x[63]}};
`endif
        do begin
            pay = 7'(v % 64'd128);
            v   = v / 64'd128;
            exp_q.push_back({v != 64'd0, pay});
        end while (v != 64'd0);
    endtask

    task automatic send_word(input logic [63:0] v);
        bit got;
        model(v);
        n_sent++;
        raw_data_valid = 1'b1;
        raw_data_in    = v;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (raw_data_accepted) got = 1'b1;
        end
        if (!got) check(1'b0, "accept_timeout", 64'd0, 64'd1);
        raw_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 500 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) check(1'b0, "idle_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_full) byte_fifo_full = ($urandom_range(0, 3) == 0);
    end

    // Monitor: pops the expected stream on every push and tracks completed words
    always @(negedge clk) begin
        if (!reset) begin
            exp_words = '0;
            prev_acc  = 1'b0;
        end else begin
            check(words_encoded == exp_words, "words_encoded", 64'(words_encoded), 64'(exp_words));
            if (raw_data_accepted) begin
                n_acc++;
                check(!prev_acc, "accept_single_cycle", 64'd1, 64'd0);
                check(busy, "busy_after_accept", 64'(busy), 64'd1);
            end
            prev_acc = raw_data_accepted;
            if (byte_out_push) begin
                n_push++;
                check(busy && !byte_fifo_full, "push_allowed", {62'd0, busy, byte_fifo_full}, 64'd2);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_push", 64'(byte_out), 64'd0);
                end else begin
                    check(byte_out == exp_q[0], "byte_out", 64'(byte_out), 64'(exp_q[0]));
                    if (!exp_q[0][7]) exp_words = exp_words + 16'd1;
                    void'(exp_q.pop_front());
                end
            end else if (busy && byte_fifo_full && exp_q.size() != 0) begin
                check(byte_out == exp_q[0], "byte_hold", 64'(byte_out), 64'(exp_q[0]));
            end
        end
    end

    initial begin
        int base;
        bit reached;
        logic [63:0] v;
        int len;

        reset          = 1'b0;
        raw_data_valid = 1'b0;
        raw_data_in    = '0;
        byte_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check({raw_data_accepted, byte_out_push, busy} == 3'b000 && byte_out == 8'h00 && words_encoded == 16'd0,
                  "reset_idle", {raw_data_accepted, byte_out_push, busy, byte_out, words_encoded}, 64'd0);
        end
        @(posedge clk); #1;

        send_word(64'd0);
        wait_idle();
        check(words_encoded == 16'd1, "words_after_zero", 64'(words_encoded), 64'd1);

        send_word(64'd300);
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle();
        check(words_encoded == 16'd3, "words_after_300_ones", 64'(words_encoded), 64'd3);

        // Backpressure right after the first byte of 150 goes out
        send_word(64'd150);
        @(posedge clk); #1 byte_fifo_full = 1'b1;
        repeat (3) @(posedge clk);
        #1 byte_fifo_full = 1'b0;
        wait_idle();
        check(words_encoded == 16'd4, "words_after_150", 64'(words_encoded), 64'd4);

        // Asynchronous reset part-way through an all-ones word
        base = n_push;
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (n_push >= base + 4) reached = 1'b1;
        end
        if (!reached) check(1'b0, "mid_reset_timeout", 64'(n_push - base), 64'd4);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check({raw_data_accepted, byte_out_push, busy} == 3'b000 && byte_out == 8'h00 && words_encoded == 16'd0,
              "async_reset_clear", {raw_data_accepted, byte_out_push, busy, byte_out, words_encoded}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_word(64'd1);
        wait_idle();
        check(words_encoded == 16'd1, "words_after_reset", 64'(words_encoded), 64'd1);

`ifdef RAW_DATA_VARINT_ZIGZAG_EN
        send_word(64'hFFFF_FFFF_FFFF_FFFF);
        send_word(64'd1);
        send_word(64'hFFFF_FFFF_FFFF_FFFE);
        send_word(-64'sd65);
        wait_idle();
`endif

        // Random words of random bit length under random backpressure, back to back
        rand_full = 1'b1;
        for (int i = 0; i < 40; i++) begin
            len = $urandom_range(0, 64);
            v = {$urandom, $urandom};
            if (len < 64) v = v & ((64'd1 << len) - 64'd1);
            send_word(v);
        end
        wait_idle();
        rand_full      = 1'b0;
        byte_fifo_full = 1'b0;
        repeat (3) @(posedge clk);

        check(exp_q.size() == 0, "leftover_bytes", 64'(exp_q.size()), 64'd0);
        check(n_acc == n_sent, "accept_count", 64'(n_acc), 64'(n_sent));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
